// File: rtl/ball_motion_ctl_if.sv
// Bus between the Pong ball motion controller and its neighbours:
// serve/pause/paddle controls in, ball position and event pulses out.
interface ball_motion_ctl_if;
    logic        serve;
    logic        serve_dir;
    logic        pause;
    logic [1:0]  difficulty;
    logic [11:0] pad_l_ypos;
    logic [11:0] pad_r_ypos;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        moving;
    logic        hit;
    logic        miss_l;
    logic        miss_r;
    logic [3:0]  speed_level;

    modport master (
        output serve, serve_dir, pause, difficulty, pad_l_ypos, pad_r_ypos,
        input  xpos, ypos, moving, hit, miss_l, miss_r, speed_level
    );
    modport slave (
        input  serve, serve_dir, pause, difficulty, pad_l_ypos, pad_r_ypos,
        output xpos, ypos, moving, hit, miss_l, miss_r, speed_level
    );
endinterface

// File: rtl/ball_motion_ctl.sv
// Two-paddle ball motion controller: steps the ball every `interval` clocks,
// bounces off walls and paddles, flags misses and speeds up after paddle hits.
module ball_motion_ctl #(
    parameter int          SCREEN_W       = 1024,
    parameter int          SCREEN_H       = 768,
    parameter int          BALL_SIZE      = 16,
    parameter int          PAD_W          = 10,
    parameter int          PAD_H          = 80,
    parameter int          PAD_L_X        = 60,
    parameter int          PAD_R_X        = 954,
    parameter logic [19:0] INTERVAL_START = 20'h80000,
    parameter logic [19:0] INTERVAL_MIN   = 20'h01000,
    parameter int          HITS_PER_STEP  = 4,
    parameter logic [19:0] SCORE_HOLD     = 20'hFFFFF
) (
    input  logic              pclk,
    input  logic              rst_n,
    ball_motion_ctl_if.slave  bus
);
    localparam logic [11:0] X0       = 12'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [11:0] Y0       = 12'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [11:0] XMAX     = 12'(SCREEN_W - BALL_SIZE);
    localparam logic [11:0] YMAX     = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [11:0] BSZ      = 12'(BALL_SIZE);
    localparam logic [11:0] PADH     = 12'(PAD_H);
    localparam logic [11:0] PADL_HIT = 12'(PAD_L_X + PAD_W);
    localparam logic [11:0] PADR_HIT = 12'(PAD_R_X);
    localparam int          HCW      = $clog2(HITS_PER_STEP + 1);
    localparam logic [HCW-1:0] HPS   = HCW'(HITS_PER_STEP);

    typedef enum logic [1:0] {S_IDLE, S_MOVING, S_PAUSED, S_SCORED} state_t;

    state_t         r_state;
    logic [11:0]    r_xpos, r_ypos;
    logic           r_vx, r_vy;
    logic [19:0]    r_tick, r_ival, r_hold;
    logic [HCW-1:0] r_hits;
    logic [3:0]     r_level;
    logic           r_moving, r_hit, r_miss_l, r_miss_r;

    logic           w_step, w_miss_l, w_miss_r, w_hit_l, w_hit_r, w_hit;
    logic           w_vx_n, w_vy_n;
    logic [11:0]    w_x_n, w_y_n, w_ybot, w_xright;
    logic [19:0]    w_ival_sub, w_ival_new;
    logic [HCW-1:0] w_hits_inc;

    // Collision decisions look only at the pre-step position and direction.
    always_comb begin
        w_step   = (r_tick == r_ival - 20'd1);
        w_ybot   = r_ypos + BSZ;
        w_xright = r_xpos + BSZ;
        w_miss_l = !r_vx && (r_xpos == 12'd0);
        w_miss_r = r_vx && (r_xpos == XMAX);
        w_hit_l  = !r_vx && (r_xpos == PADL_HIT) &&
                   (w_ybot > bus.pad_l_ypos) && (r_ypos < bus.pad_l_ypos + PADH);
        w_hit_r  = r_vx && (w_xright == PADR_HIT) &&
                   (w_ybot > bus.pad_r_ypos) && (r_ypos < bus.pad_r_ypos + PADH);
        w_hit    = w_hit_l || w_hit_r;
        w_vy_n   = r_vy;
        if (r_ypos == 12'd0 && !r_vy)
            w_vy_n = 1'b1;
        else if (r_ypos == YMAX && r_vy)
            w_vy_n = 1'b0;
        w_vx_n   = w_hit_l ? 1'b1 : (w_hit_r ? 1'b0 : r_vx);
        w_x_n    = w_vx_n ? r_xpos + 12'd1 : r_xpos - 12'd1;
        w_y_n    = w_vy_n ? r_ypos + 12'd1 : r_ypos - 12'd1;
        w_hits_inc = r_hits + 1'b1;
        w_ival_sub = r_ival - (r_ival >> ({1'b0, bus.difficulty} + 3'd2));
        w_ival_new = (w_ival_sub < INTERVAL_MIN) ? INTERVAL_MIN : w_ival_sub;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_xpos   <= X0;
            r_ypos   <= Y0;
            r_vx     <= 1'b0;
            r_vy     <= 1'b0;
            r_tick   <= '0;
            r_ival   <= INTERVAL_START;
            r_hold   <= '0;
            r_hits   <= '0;
            r_level  <= '0;
            r_moving <= 1'b0;
            r_hit    <= 1'b0;
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
        end else begin
            r_hit    <= 1'b0;
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_xpos <= X0;
                    r_ypos <= Y0;
                    r_tick <= '0;
                    if (bus.serve) begin
                        r_state  <= S_MOVING;
                        r_moving <= 1'b1;
                        r_vx     <= bus.serve_dir;
                        r_vy     <= 1'b0;
                    end
                end
                S_MOVING: begin
                    if (bus.pause) begin
                        r_state <= S_PAUSED;
                    end else if (!w_step) begin
                        r_tick <= r_tick + 20'd1;
                    end else begin
                        r_tick <= '0;
                        if (w_miss_l || w_miss_r) begin
                            r_miss_l <= w_miss_l;
                            r_miss_r <= w_miss_r;
                            r_state  <= S_SCORED;
                            r_moving <= 1'b0;
                            r_hold   <= '0;
                        end else begin
                            r_vx   <= w_vx_n;
                            r_vy   <= w_vy_n;
                            r_xpos <= w_x_n;
                            r_ypos <= w_y_n;
                            r_hit  <= w_hit;
                            if (w_hit) begin
                                if (w_hits_inc == HPS) begin
                                    r_hits <= '0;
                                    r_ival <= w_ival_new;
                                    if (r_level != 4'hF)
                                        r_level <= r_level + 4'd1;
                                end else begin
                                    r_hits <= w_hits_inc;
                                end
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (!bus.pause)
                        r_state <= S_MOVING;
                end
                S_SCORED: begin
                    // Speed state resets on the same edge the ball returns home.
                    if (r_hold == SCORE_HOLD - 20'd1) begin
                        r_state <= S_IDLE;
                        r_xpos  <= X0;
                        r_ypos  <= Y0;
                        r_ival  <= INTERVAL_START;
                        r_hits  <= '0;
                        r_level <= '0;
                    end else begin
                        r_hold <= r_hold + 20'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.xpos        = r_xpos;
    assign bus.ypos        = r_ypos;
    assign bus.moving      = r_moving;
    assign bus.hit         = r_hit;
    assign bus.miss_l      = r_miss_l;
    assign bus.miss_r      = r_miss_r;
    assign bus.speed_level = r_level;
endmodule

// File: tb/tb_ball_motion_ctl.sv
// Bench for ball_motion_ctl: two instances (fast small field, slow speed-up
// field) checked every cycle against a behavioural model plus literal points.
module tb_ball_motion_ctl;
    typedef struct packed {
        int W, H, B, PW, PH, PLX, PRX, IS, IMIN, HPS, HOLD;
    } prm_t;
    typedef struct packed {
        int mode; // 0 idle, 1 moving, 2 paused, 3 scored
        int x, y, vx, vy, ph, ival, hits, lvl, hold, hit, ml, mr;
    } mdl_t;

    localparam prm_t PA = '{64, 48, 4, 2, 8, 4, 58, 4, 2, 2, 10};
    localparam prm_t PB = '{24, 16, 4, 2, 16, 2, 20, 4096, 4000, 1, 4};

    logic pclk = 1'b0;
    logic rst_a, rst_b;
    logic chk_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    mdl_t ma, mb;

    ball_motion_ctl_if ifa();
    ball_motion_ctl_if ifb();

    ball_motion_ctl #(
        .SCREEN_W(64), .SCREEN_H(48), .BALL_SIZE(4), .PAD_W(2), .PAD_H(8),
        .PAD_L_X(4), .PAD_R_X(58), .INTERVAL_START(20'd4), .INTERVAL_MIN(20'd2),
        .HITS_PER_STEP(2), .SCORE_HOLD(20'd10)
    ) dut_a (.pclk(pclk), .rst_n(rst_a), .bus(ifa));

    ball_motion_ctl #(
        .SCREEN_W(24), .SCREEN_H(16), .BALL_SIZE(4), .PAD_W(2), .PAD_H(16),
        .PAD_L_X(2), .PAD_R_X(20), .INTERVAL_START(20'd4096), .INTERVAL_MIN(20'd4000),
        .HITS_PER_STEP(1), .SCORE_HOLD(20'd4)
    ) dut_b (.pclk(pclk), .rst_n(rst_b), .bus(ifb));

    always #5 pclk = ~pclk;

    function automatic mdl_t home(prm_t p);
        mdl_t n;
        n = '0;
        n.x = (p.W - p.B) / 2;
        n.y = (p.H - p.B) / 2;
        n.ival = p.IS;
        return n;
    endfunction

    function automatic bit overlap(int y, int pad, prm_t p);
        return (((y + p.B) & 4095) > pad) && (y < ((pad + p.PH) & 4095));
    endfunction

    function automatic mdl_t mstep(mdl_t m, prm_t p, logic rst, logic srv, logic sdir,
                                   logic pse, logic [1:0] dif, int pl, int pr);
        mdl_t n;
        if (!rst) return home(p);
        n = m;
        n.hit = 0; n.ml = 0; n.mr = 0;
        case (m.mode)
            0: if (srv) begin n.mode = 1; n.vx = int'(sdir); n.vy = 0; n.ph = 0; end
            1: begin
                if (pse) n.mode = 2;
                else if (m.ph != m.ival - 1) n.ph = m.ph + 1;
                else begin
                    n.ph = 0;
                    if (m.vx == 0 && m.x == 0) begin n.ml = 1; n.mode = 3; n.hold = 0; end
                    else if (m.vx == 1 && m.x == p.W - p.B) begin n.mr = 1; n.mode = 3; n.hold = 0; end
                    else begin
                        if (m.y == 0 && m.vy == 0) n.vy = 1;
                        else if (m.y == p.H - p.B && m.vy == 1) n.vy = 0;
                        if (m.vx == 0 && m.x == p.PLX + p.PW && overlap(m.y, pl, p)) begin
                            n.vx = 1; n.hit = 1;
                        end else if (m.vx == 1 && ((m.x + p.B) & 4095) == p.PRX && overlap(m.y, pr, p)) begin
                            n.vx = 0; n.hit = 1;
                        end
                        n.x = (m.x + (n.vx != 0 ? 1 : -1)) & 4095;
                        n.y = (m.y + (n.vy != 0 ? 1 : -1)) & 4095;
                        if (n.hit != 0) begin
                            n.hits = m.hits + 1;
                            if (n.hits == p.HPS) begin
                                n.hits = 0;
                                n.ival = m.ival - (m.ival >> (int'(dif) + 2));
                                if (n.ival < p.IMIN) n.ival = p.IMIN;
                                if (m.lvl < 15) n.lvl = m.lvl + 1;
                            end
                        end
                    end
                end
            end
            2: if (!pse) n.mode = 1;
            default: if (m.hold == p.HOLD - 1) n = home(p); else n.hold = m.hold + 1;
        endcase
        return n;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    always @(posedge pclk) begin
        ma = mstep(ma, PA, rst_a, ifa.serve, ifa.serve_dir, ifa.pause, ifa.difficulty,
                   int'(ifa.pad_l_ypos), int'(ifa.pad_r_ypos));
        mb = mstep(mb, PB, rst_b, ifb.serve, ifb.serve_dir, ifb.pause, ifb.difficulty,
                   int'(ifb.pad_l_ypos), int'(ifb.pad_r_ypos));
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            check("A.xpos", 32'(ifa.xpos), ma.x);
            check("A.ypos", 32'(ifa.ypos), ma.y);
            check("A.moving", 32'(ifa.moving), (ma.mode == 1 || ma.mode == 2) ? 1 : 0);
            check("A.hit", 32'(ifa.hit), ma.hit);
            check("A.miss_l", 32'(ifa.miss_l), ma.ml);
            check("A.miss_r", 32'(ifa.miss_r), ma.mr);
            check("A.speed_level", 32'(ifa.speed_level), ma.lvl);
            check("B.xpos", 32'(ifb.xpos), mb.x);
            check("B.ypos", 32'(ifb.ypos), mb.y);
            check("B.moving", 32'(ifb.moving), (mb.mode == 1 || mb.mode == 2) ? 1 : 0);
            check("B.hit", 32'(ifb.hit), mb.hit);
            check("B.miss_l", 32'(ifb.miss_l), mb.ml);
            check("B.miss_r", 32'(ifb.miss_r), mb.mr);
            check("B.speed_level", 32'(ifb.speed_level), mb.lvl);
        end
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.serve = 0; ifa.serve_dir = 0; ifa.pause = 0; ifa.difficulty = 2'd0;
        ifa.pad_l_ypos = 12'd40; ifa.pad_r_ypos = 12'd40;
        ifb.serve = 0; ifb.serve_dir = 0; ifb.pause = 0; ifb.difficulty = 2'd0;
        ifb.pad_l_ypos = 12'd0; ifb.pad_r_ypos = 12'd0;
        tick(2);
        chk_en = 1'b1;
        check("lit.reset.x", 32'(ifa.xpos), 30);
        check("lit.reset.y", 32'(ifa.ypos), 22);
        check("lit.reset.moving", 32'(ifa.moving), 0);
        check("lit.resetB.x", 32'(ifb.xpos), 10);
        rst_a = 1'b1; rst_b = 1'b1;
        tick(2);

        // Rightward serve: top-wall bounce, then right exit past a high paddle.
        ifa.serve = 1; ifa.serve_dir = 1;
        tick(1);
        ifa.serve = 0;
        check("lit.serve.moving", 32'(ifa.moving), 1);
        tick(3);
        check("lit.prestep.x", 32'(ifa.xpos), 30);
        tick(1);
        check("lit.step1.x", 32'(ifa.xpos), 31);
        check("lit.step1.y", 32'(ifa.ypos), 21);
        ifa.serve = 1; ifa.serve_dir = 0;
        tick(1);
        ifa.serve = 0;
        for (int i = 0; i < 200 && ifa.ypos != 12'd0; i++) tick(1);
        check("lit.top.y", 32'(ifa.ypos), 0);
        check("lit.top.x", 32'(ifa.xpos), 52);
        for (int i = 0; i < 20 && ifa.ypos == 12'd0; i++) tick(1);
        check("lit.bounce.y", 32'(ifa.ypos), 1);
        check("lit.bounce.x", 32'(ifa.xpos), 53);
        for (int i = 0; i < 200 && ifa.miss_r !== 1'b1; i++) tick(1);
        check("lit.miss_r", 32'(ifa.miss_r), 1);
        check("lit.miss_r.x", 32'(ifa.xpos), 60);
        check("lit.miss_r.y", 32'(ifa.ypos), 8);
        tick(9);
        check("lit.scored.x", 32'(ifa.xpos), 60);
        tick(1);
        check("lit.home.x", 32'(ifa.xpos), 30);
        check("lit.home.y", 32'(ifa.ypos), 22);

        // Leftward serve with paddle present: pause, left paddle hit, reset.
        ifa.pad_l_ypos = 12'd0;
        ifa.serve = 1; ifa.serve_dir = 0;
        tick(1);
        ifa.serve = 0;
        tick(12);
        check("lit.step3.x", 32'(ifa.xpos), 27);
        tick(2);
        ifa.pause = 1;
        tick(100);
        check("lit.pause.x", 32'(ifa.xpos), 27);
        check("lit.pause.y", 32'(ifa.ypos), 19);
        check("lit.pause.moving", 32'(ifa.moving), 1);
        ifa.pause = 0;
        for (int i = 0; i < 400 && ifa.hit !== 1'b1; i++) tick(1);
        check("lit.hit", 32'(ifa.hit), 1);
        check("lit.hit.x", 32'(ifa.xpos), 7);
        check("lit.hit.y", 32'(ifa.ypos), 3);
        tick(2);
        rst_a = 1'b0;
        tick(1);
        check("lit.rst.x", 32'(ifa.xpos), 30);
        check("lit.rst.y", 32'(ifa.ypos), 22);
        check("lit.rst.moving", 32'(ifa.moving), 0);
        rst_a = 1'b1;

        // Leftward serve with paddle absent: left miss and return home.
        ifa.pad_l_ypos = 12'd40;
        tick(1);
        ifa.serve = 1; ifa.serve_dir = 0;
        tick(1);
        ifa.serve = 0;
        for (int i = 0; i < 400 && ifa.miss_l !== 1'b1; i++) tick(1);
        check("lit.miss_l", 32'(ifa.miss_l), 1);
        check("lit.miss_l.x", 32'(ifa.xpos), 0);
        check("lit.miss_l.y", 32'(ifa.ypos), 8);
        tick(10);
        check("lit.home2.x", 32'(ifa.xpos), 30);
        check("lit.home2.moving", 32'(ifa.moving), 0);

        // Slow instance: corner hit on the left paddle, clamped speed-up.
        ifb.serve = 1; ifb.serve_dir = 0;
        tick(1);
        ifb.serve = 0;
        for (int i = 0; i < 30000 && ifb.hit !== 1'b1; i++) tick(1);
        check("lit.B.hit", 32'(ifb.hit), 1);
        check("lit.B.corner.x", 32'(ifb.xpos), 5);
        check("lit.B.corner.y", 32'(ifb.ypos), 1);
        check("lit.B.level", 32'(ifb.speed_level), 1);
        tick(3999);
        check("lit.B.prestep.x", 32'(ifb.xpos), 5);
        tick(1);
        check("lit.B.fast.x", 32'(ifb.xpos), 6);
        check("lit.B.fast.y", 32'(ifb.ypos), 2);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ball_motion_ctl.md
# ball_motion_ctl

Parametrised two-paddle ball motion controller for the Pong video pipeline. Advances the ball one pixel per axis every `interval` pixel clocks, reflects off top and bottom walls and both paddles, detects misses, and speeds the ball up after a configurable number of paddle hits. It replaces the single-paddle controller and feeds `xpos` and `ypos` to the ball drawing stage.

## Interface
- `SCREEN_W`, default 1024: playfield width in pixels.
- `SCREEN_H`, default 768: playfield height in pixels.
- `BALL_SIZE`, default 16: ball edge length in pixels.
- `PAD_W`, default 10: paddle width.
- `PAD_H`, default 80: paddle height.
- `PAD_L_X`, default 60: x of the left paddle's left edge.
- `PAD_R_X`, default 954: x of the right paddle's left edge.
- `INTERVAL_START`, default 20'h80000: initial clocks per step.
- `INTERVAL_MIN`, default 20'h01000: lower bound on the interval.
- `HITS_PER_STEP`, default 4: paddle hits per speed-up.
- `SCORE_HOLD`, default 20'hFFFFF: clocks spent in SCORED.
- `pclk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset. One clock; reset is synchronous and active-low.
- `serve`, in, 1: single-cycle request to launch the ball.
- `serve_dir`, in, 1: launch direction. 0 = leftward, 1 = rightward. Launch is always upward.
- `pause`, in, 1: level-sensitive freeze.
- `difficulty`, in, 2: speed-up shift select.
- `pad_l_ypos`, in, 12: top y of the left paddle.
- `pad_r_ypos`, in, 12: top y of the right paddle.
- `xpos`, out, 12: ball top-left x.
- `ypos`, out, 12: ball top-left y.
- `moving`, out, 1: high in MOVING and PAUSED.
- `hit`, out, 1: one-cycle pulse on each paddle reflection.
- `miss_l`, out, 1: one-cycle pulse when the ball exits on the left.
- `miss_r`, out, 1: one-cycle pulse when the ball exits on the right.
- `speed_level`, out, 4: number of speed-ups applied. Saturates at 15.

## Operation
- Home position: X0 = (SCREEN_W−BALL_SIZE)/2 and Y0 = (SCREEN_H−BALL_SIZE)/2.
- Direction is held as two bits:
  - `vx`: 1 = right.
  - `vy`: 1 = down.
- States are IDLE, MOVING, PAUSED and SCORED.
- IDLE:
  - Ball is held at (X0, Y0).
  - `interval` = INTERVAL_START, `speed_level` = 0, hit counter = 0.
  - On `serve`: `vx` = `serve_dir`, `vy` = 0, go to MOVING.
- MOVING: a tick counter counts 0..interval−1. When the count reaches interval−1 (a step cycle), collisions are evaluated on the current position and direction:
  - Top wall: `ypos` == 0 with `vy`=0 → `vy`=1.
  - Bottom wall: `ypos` == SCREEN_H−BALL_SIZE with `vy`=1 → `vy`=0.
  - Left paddle: `vx`=0, `xpos` == PAD_L_X+PAD_W, and `ypos`+BALL_SIZE > `pad_l_ypos` and `ypos` < `pad_l_ypos`+PAD_H → `vx`=1, pulse `hit`.
  - Right paddle: `vx`=1, `xpos`+BALL_SIZE == PAD_R_X, and the same vertical overlap against `pad_r_ypos` → `vx`=0, pulse `hit`.
  - Left miss: `xpos` == 0 with `vx`=0 → pulse `miss_l`, go to SCORED, position is not updated.
  - Right miss: `xpos` == SCREEN_W−BALL_SIZE with `vx`=1 → pulse `miss_r`, go to SCORED, position is not updated.
  - Otherwise the position steps by ±1 per axis using the updated direction bits.
  - A wall and a paddle event in the same step both apply, so a corner hit flips both axes.
- Speed-up:
  - Each `hit` increments the hit counter.
  - When the counter reaches HITS_PER_STEP, it clears and `interval` ← max(INTERVAL_MIN, interval − (interval >> (difficulty+2))).
  - `speed_level` increments on each speed-up, saturating at 15.
  - The new interval takes effect from the next tick period.
- `pause` in MOVING → PAUSED. The tick counter, position and direction are frozen. Deasserting `pause` returns to MOVING.
- `serve` is ignored outside IDLE.
- SCORED: ball is held at the miss position for SCORE_HOLD clocks, then IDLE.
- All arithmetic is unsigned 12-bit for position and 20-bit for the interval.

## Timing
- All outputs are registered.
- Reset values: `xpos`=X0, `ypos`=Y0, `moving`=0, `hit`=0, `miss_l`=0, `miss_r`=0, `speed_level`=0. State = IDLE, `interval`=INTERVAL_START.
- Reset mid-operation:
  - Restores all of the above on the next edge.
  - Drops any pulse that was due.
- `serve` sampled at edge N gives `moving`=1 after edge N. The first step happens at edge N+INTERVAL_START.
- Position, `hit` and miss pulses all update on the step-cycle edge, with zero additional latency.
- Paddle inputs are sampled only on step cycles.
- `pause` is sampled every cycle. Pausing on a step cycle suppresses that step.

## Test plan
- Serve, default params, `serve_dir`=1 → `moving`=1 after one cycle, first step to (505,375) after 0x80000 clocks.
- Small params (SCREEN 64×48, INTERVAL_START 4), ball ascending to the top wall → `ypos` turns from 0 to 1, and `xpos` keeps incrementing.
- Left paddle aligned, `vx`=0 at `xpos`=PAD_L_X+PAD_W → `hit` pulse, `vx`=1, `xpos` increments on that edge.
- Paddle absent at the left exit → `miss_l` on the step where `xpos`=0, SCORED for SCORE_HOLD clocks, then IDLE at (X0,Y0).
- HITS_PER_STEP hits with `difficulty`=0, interval 4096, INTERVAL_MIN 4000 → interval 4000 (clamped), `speed_level`=1. Corner hit flips both `vx` and `vy`.
- `pause` held 100 clocks mid-period → position and tick count are unchanged. Assert `rst_n`=0 during MOVING → all reset values on the next edge.
